// File: rtl/simple_dual_port_ram_if.sv
// Port bundle for the simple dual-port RAM.
// Carries the write port A and read port B signals.
interface sdpram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int OUT_REG    = 0
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int RD_LATENCY = (OUT_REG != 0) ? 2 : 1;

    logic [STRB_WIDTH-1:0] wena;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  renb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  doutb_valid;

    modport ram (
        input  wena,
        input  addra,
        input  dina,
        input  renb,
        input  addrb,
        output doutb,
        output doutb_valid
    );

    modport drv (
        output wena,
        output addra,
        output dina,
        output renb,
        output addrb,
        input  doutb,
        input  doutb_valid
    );
endinterface

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: byte-strobed write port A, read port B.
// Read-first on collisions, optional output register stage.
module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int OUT_REG    = 0
) (
    input logic   clk,
    input logic   rst,
    sdpram_if.ram ifp
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_d;
    logic                  rd_valid_q;

    // Addresses beyond the array are ignored on write, read back as 0.
    always_comb begin
        wr_in_range = ({1'b0, ifp.addra} < DEPTH_W);
        rd_in_range = ({1'b0, ifp.addrb} < DEPTH_W);
    end

    // Byte-masked write; array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_in_range) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (ifp.wena[i]) begin
                    mem[ifp.addra][i*8 +: 8] <= ifp.dina[i*8 +: 8];
                end
            end
        end
    end

    // Read stage: samples the pre-write contents, holds when idle.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rst) begin
            rd_data_d = '0;
        end else if (ifp.renb) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_in_range ? mem[ifp.addrb] : '0;
        end
    end

    // Read stage register.
    always_ff @(posedge clk) begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_d;
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_d;
        logic                  out_valid_q;

        // Output stage: forwards fresh data, reset drops in-flight reads.
        always_comb begin
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
            if (rst) begin
                out_data_d = '0;
            end else if (rd_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = rd_data_q;
            end
        end

        // Output stage register.
        always_ff @(posedge clk) begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end

        assign ifp.doutb       = out_data_q;
        assign ifp.doutb_valid = out_valid_q;
    end else begin : g_direct
        assign ifp.doutb       = rd_data_q;
        assign ifp.doutb_valid = rd_valid_q;
    end
endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Bench for simple_dual_port_ram: latency-1 and latency-2 instances
// driven in lockstep and checked against a word-array reference.
module tb_simple_dual_port_ram;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  wena;
    logic [9:0]  addra;
    logic [31:0] dina;
    logic        renb;
    logic [9:0]  addrb;

    sdpram_if #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .OUT_REG(0)) if0 ();
    sdpram_if #(.DATA_WIDTH(32), .MEM_DEPTH(1000), .OUT_REG(1)) if1 ();

    assign if0.wena  = wena;
    assign if0.addra = addra;
    assign if0.dina  = dina;
    assign if0.renb  = renb;
    assign if0.addrb = addrb;
    assign if1.wena  = wena;
    assign if1.addra = addra;
    assign if1.dina  = dina;
    assign if1.renb  = renb;
    assign if1.addrb = addrb;

    simple_dual_port_ram #(
        .DATA_WIDTH(32), .MEM_DEPTH(1024), .OUT_REG(0)
    ) dut0 (
        .clk(clk), .rst(rst), .ifp(if0.ram)
    );

    simple_dual_port_ram #(
        .DATA_WIDTH(32), .MEM_DEPTH(1000), .OUT_REG(1)
    ) dut1 (
        .clk(clk), .rst(rst), .ifp(if1.ram)
    );

    // Reference memories (one per depth) and per-edge request history.
    logic [31:0] m0 [1024];
    logic [31:0] m1 [1024];
    bit          h_rst [4096];
    bit          h_ren [4096];
    logic [31:0] h_d0  [4096];
    logic [31:0] h_d1  [4096];
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    int          k = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: record request, update model, then compare both DUTs.
    task automatic step();
        logic [31:0] ed0, ed1;
        logic        ev0, ev1;
        h_rst[k] = rst;
        h_ren[k] = renb;
        h_d0[k]  = m0[addrb];
        h_d1[k]  = (addrb < 10'd1000) ? m1[addrb] : 32'h0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wena[i]) begin
                    m0[addra][i*8 +: 8] = dina[i*8 +: 8];
                    if (addra < 10'd1000) m1[addra][i*8 +: 8] = dina[i*8 +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        if (h_rst[k]) begin
            ev0 = 1'b0; last0 = '0;
        end else if (h_ren[k]) begin
            ev0 = 1'b1; last0 = h_d0[k];
        end else begin
            ev0 = 1'b0;
        end
        ed0 = last0;
        if (h_rst[k] || (k > 0 && h_rst[k-1])) begin
            ev1 = 1'b0; last1 = '0;
        end else if (k > 0 && h_ren[k-1]) begin
            ev1 = 1'b1; last1 = h_d1[k-1];
        end else begin
            ev1 = 1'b0;
        end
        ed1 = last1;
        chk("lat1_valid", {31'b0, if0.doutb_valid}, {31'b0, ev0});
        chk("lat1_data", if0.doutb, ed0);
        chk("lat2_valid", {31'b0, if1.doutb_valid}, {31'b0, ev1});
        chk("lat2_data", if1.doutb, ed1);
        k++;
    endtask

    task automatic wr(input logic [9:0] a, input logic [3:0] s,
                      input logic [31:0] d);
        wena = s; addra = a; dina = d;
    endtask

    task automatic rd(input logic [9:0] a);
        renb = 1'b1; addrb = a;
    endtask

    task automatic idle();
        wena = '0; renb = 1'b0; addra = '0; addrb = '0; dina = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        chk("rst_dout0", if0.doutb, 32'h0);
        chk("rst_dout1", if1.doutb, 32'h0);
        rst = 1'b0;

        // Fill the low region so every later read is well defined.
        for (int a = 0; a < 64; a++) begin
            wr(10'(a), 4'hF, $urandom);
            step();
        end
        idle();

        // Full-word write then read.
        wr(10'h005, 4'hF, 32'hDEADBEEF); step(); idle();
        rd(10'h005); step(); idle();
        chk("wr_rd_lat1", if0.doutb, 32'hDEADBEEF);
        step();
        chk("wr_rd_lat2", if1.doutb, 32'hDEADBEEF);

        // Single byte strobe.
        wr(10'h005, 4'b0010, 32'h00001200); step(); idle();
        rd(10'h005); step(); idle();
        chk("strb_lat1", if0.doutb, 32'hDEAD12EF);
        step();
        chk("strb_lat2", if1.doutb, 32'hDEAD12EF);

        // Empty strobe must not modify memory.
        wr(10'h005, 4'h0, 32'h01234567); step(); idle();

        // Read-first collision.
        wr(10'h010, 4'hF, 32'h11111111); step(); idle();
        wr(10'h010, 4'hF, 32'h22222222); rd(10'h010); step(); idle();
        chk("coll_lat1", if0.doutb, 32'h11111111);
        rd(10'h010); step(); idle();
        chk("coll_next_lat1", if0.doutb, 32'h22222222);
        chk("coll_lat2", if1.doutb, 32'h11111111);
        step();
        chk("coll_next_lat2", if1.doutb, 32'h22222222);

        // Reset clears outputs, keeps memory, first read after completes.
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_d0", if0.doutb, 32'h0);
        chk("rst_mid_v1", {31'b0, if1.doutb_valid}, 32'h0);
        rd(10'h005); step(); idle();
        chk("post_rst_lat1", if0.doutb, 32'hDEAD12EF);
        step();
        chk("post_rst_lat2", if1.doutb, 32'hDEAD12EF);

        // Reset while a latency-2 read is in flight.
        rd(10'h005); step(); idle();
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("inflight_drop", {31'b0, if1.doutb_valid}, 32'h0);

        // Address 1005 exists in the 1024 instance, not in the 1000 one.
        wr(10'd1005, 4'hF, 32'hCAFEF00D); step(); idle();
        rd(10'd1005); step(); idle();
        chk("oor_lat1", if0.doutb, 32'hCAFEF00D);
        step();
        chk("oor_lat2_data", if1.doutb, 32'h0);
        chk("oor_lat2_valid", {31'b0, if1.doutb_valid}, 32'h1);

        // Back-to-back stream.
        for (int a = 0; a < 4; a++) begin
            rd(10'(a)); step();
        end
        idle(); step(); step();

        // Randomised traffic over the pre-filled region.
        for (int n = 0; n < 100; n++) begin
            wr(10'($urandom_range(0, 63)), 4'($urandom), $urandom);
            renb  = ($urandom_range(0, 9) < 7);
            addrb = 10'($urandom_range(0, 63));
            step();
        end
        idle(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simple_dual_port_ram.md
SIMPLE_DUAL_PORT_RAM -- requirements
Module: simple_dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter MEM_DEPTH, default 1024: number of words.
REQ-003 Parameter OUT_REG, default 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
REQ-004 Derived ADDR_WIDTH = clog2(MEM_DEPTH) and STRB_WIDTH = DATA_WIDTH/8; both SHALL be exported by interface sdpram_if.
REQ-005 The block has one clock, clk, and the reset rst is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ifp  interface  sdpram_if #(DATA_WIDTH, MEM_DEPTH, OUT_REG)  bundle carrying the port signals below.
REQ-009 ifp.wena  input  STRB_WIDTH  port-A byte write strobes; bit i enables byte i.
REQ-010 ifp.addra  input  ADDR_WIDTH  port-A write word address.
REQ-011 ifp.dina  input  DATA_WIDTH  port-A write data.
REQ-012 ifp.renb  input  1  port-B read enable.
REQ-013 ifp.addrb  input  ADDR_WIDTH  port-B read word address.
REQ-014 ifp.doutb  output  DATA_WIDTH  port-B read data.
REQ-015 ifp.doutb_valid  output  1  high for one cycle when doutb carries fresh read data.

Function
REQ-016 Port A is write-only and port B is read-only; both SHALL operate in the same cycle without stalls.
REQ-017 On a clk edge with rst low, for each set bit i of wena, mem[addra] byte i SHALL take dina byte i; unset bytes SHALL be unchanged.
REQ-018 wena = 0 SHALL leave memory unchanged.
REQ-019 An address >= MEM_DEPTH SHALL be ignored: a write to it has no effect, and a read from it returns 0 with doutb_valid still asserted.
REQ-020 With OUT_REG = 0, on an edge with renb high, doutb SHALL show mem[addrb] after that edge (latency 1), and doutb_valid SHALL be high for that cycle.
REQ-021 With OUT_REG = 1, data and doutb_valid SHALL appear one cycle later (latency 2), and reads SHALL be fully pipelined at one per cycle.
REQ-022 With renb low, doutb SHALL hold its last value and doutb_valid SHALL be low.
REQ-023 A same-cycle read and write to the same address SHALL be read-first: doutb returns the pre-write contents, and the new data is visible from the next read.
REQ-024 Writes to different addresses in consecutive cycles SHALL all be retained; the last write to an address wins.
REQ-025 Memory SHALL have no initial value requirement; reads of never-written words are undefined (X in simulation).
REQ-026 The design SHALL be inferable as block RAM: no reset on the array, and a registered read.

Reset
REQ-027 While rst is high at a clk edge, doutb SHALL become 0, doutb_valid 0, and the OUT_REG pipeline stage SHALL be cleared.
REQ-028 While rst is high, writes SHALL be suppressed and read requests dropped; memory contents SHALL be preserved across reset.
REQ-029 A read issued in the cycle rst deasserts SHALL complete normally with the stated latency.
REQ-030 Reset asserted mid-read (OUT_REG = 1) SHALL discard the in-flight result, so no doutb_valid is produced for it.

Verification
REQ-031 Write: wena=4'hF, addra=0x005, dina=0xDEADBEEF; next cycle renb=1, addrb=0x005 -> doutb=0xDEADBEEF with doutb_valid one cycle later.
REQ-032 Byte strobe: after the 0x005 write above, wena=4'b0010, dina=0x00001200 -> a read of 0x005 returns 0xDEAD12EF.
REQ-033 Collision: mem[0x010]=0x11111111; same cycle wena=4'hF, addra=addrb=0x010, dina=0x22222222, renb=1 -> doutb=0x11111111, and a subsequent read returns 0x22222222.
REQ-034 Reset: after the reads above, rst=1 for one cycle -> doutb=0 and doutb_valid=0; a read of 0x005 afterwards returns 0xDEAD12EF.
REQ-035 Random: 100 iterations of a random addra, wena, and dina with a scoreboard model, plus random reads at addrb -> every doutb matches the model with the correct latency for OUT_REG = 0 and 1.
REQ-036 Back-to-back: renb held high over addrb 0,1,2,3 -> doutb streams mem[0..3] on consecutive cycles with doutb_valid continuously high.
